id_ex_stage: RTL

Operand-latch stage between the register file's combinational read ports and the ALU. It captures decoded instruction fields plus `rd1`/`rd2` at the ID→EX boundary. It resolves RAW hazards by forwarding from the MEM stage and detects load-use hazards, inserting one bubble when needed. It also honours downstream hold and branch flush requests.

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/id_ex_stage_if.sv | 50 +++++
 rtl/fwd_sel.sv | 17 +
 rtl/id_ex_stage.sv | 68 ++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared widths and types for the ID/EX operand-latch slice.
package cpu_pkg;
  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int CTRL_W = 8;

  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  typedef logic [CTRL_W-1:0] ctrl_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [REG_AW-1:0] reg_t;

  typedef struct packed {
    logic  valid;
    reg_t  rs;
    reg_t  rt;
    reg_t  dst;
    logic  wreg;
    logic  memread;
    ctrl_t ctrl;
    data_t imm;
    data_t a;
    data_t b;
  } ex_regs_t;
endpackage

// File: rtl/id_ex_stage_if.sv
// ID-side, MEM-side and EX-side signals of the ID/EX boundary.
interface id_ex_stage_if;
  import cpu_pkg::*;

  logic  id_valid;
  reg_t  id_rs;
  reg_t  id_rt;
  logic  id_use_rs;
  logic  id_use_rt;
  data_t id_rd1;
  data_t id_rd2;
  data_t id_imm;
  reg_t  id_dst;
  logic  id_wreg;
  logic  id_memread;
  ctrl_t id_ctrl;
  logic  mem_wreg;
  reg_t  mem_dst;
  data_t mem_wd;
  logic  ex_stall;
  logic  flush;

  logic  id_stall;
  logic  ex_valid;
  data_t ex_a;
  data_t ex_b;
  data_t ex_imm;
  reg_t  ex_dst;
  ctrl_t ex_ctrl;
  reg_t  ex_rs;
  reg_t  ex_rt;
  logic  ex_wreg;
  logic  ex_memread;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rd1, id_rd2,
           id_imm, id_dst, id_wreg, id_memread, id_ctrl,
           mem_wreg, mem_dst, mem_wd, ex_stall, flush,
    input  id_stall, ex_valid, ex_a, ex_b, ex_imm, ex_dst, ex_ctrl,
           ex_rs, ex_rt, ex_wreg, ex_memread
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rd1, id_rd2,
           id_imm, id_dst, id_wreg, id_memread, id_ctrl,
           mem_wreg, mem_dst, mem_wd, ex_stall, flush,
    output id_stall, ex_valid, ex_a, ex_b, ex_imm, ex_dst, ex_ctrl,
           ex_rs, ex_rt, ex_wreg, ex_memread
  );
endinterface

// File: rtl/fwd_sel.sv
// Single forwarding mux: producer data wins on a non-zero register match.
module fwd_sel
  import cpu_pkg::*;
(
  input  logic  wreg,
  input  reg_t  dst,
  input  reg_t  src,
  input  data_t fwd_data,
  input  data_t reg_data,
  output data_t sel_data
);
  always_comb begin
    sel_data = reg_data;
    if (wreg && (dst == src) && (src != REG_ZERO))
      sel_data = fwd_data;
  end
endmodule

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with MEM forwarding, load-use bubble, hold and flush.
module id_ex_stage
  import cpu_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  id_ex_stage_if.slave bus
);
  ex_regs_t state_q, state_d;
  data_t    cap_a, cap_b, ex_a, ex_b;
  logic     lu;

  fwd_sel u_cap_a (.wreg(bus.mem_wreg), .dst(bus.mem_dst), .src(bus.id_rs),
                   .fwd_data(bus.mem_wd), .reg_data(bus.id_rd1), .sel_data(cap_a));
  fwd_sel u_cap_b (.wreg(bus.mem_wreg), .dst(bus.mem_dst), .src(bus.id_rt),
                   .fwd_data(bus.mem_wd), .reg_data(bus.id_rd2), .sel_data(cap_b));
  fwd_sel u_ex_a  (.wreg(bus.mem_wreg), .dst(bus.mem_dst), .src(state_q.rs),
                   .fwd_data(bus.mem_wd), .reg_data(state_q.a), .sel_data(ex_a));
  fwd_sel u_ex_b  (.wreg(bus.mem_wreg), .dst(bus.mem_dst), .src(state_q.rt),
                   .fwd_data(bus.mem_wd), .reg_data(state_q.b), .sel_data(ex_b));

  always_comb begin
    lu = state_q.valid && state_q.memread && (state_q.dst != REG_ZERO) &&
         ((bus.id_use_rs && (bus.id_rs == state_q.dst)) ||
          (bus.id_use_rt && (bus.id_rt == state_q.dst)));
  end

  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d.valid = 1'b0;
    end else if (bus.ex_stall) begin
      // Re-latch the forwarded operands so they survive the producer leaving MEM.
      state_d.a = ex_a;
      state_d.b = ex_b;
    end else if (lu) begin
      state_d.valid = 1'b0;
    end else begin
      state_d.valid   = bus.id_valid;
      state_d.rs      = bus.id_rs;
      state_d.rt      = bus.id_rt;
      state_d.dst     = bus.id_dst;
      state_d.wreg    = bus.id_wreg;
      state_d.memread = bus.id_memread;
      state_d.ctrl    = bus.id_ctrl;
      state_d.imm     = bus.id_imm;
      state_d.a       = cap_a;
      state_d.b       = cap_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= '0;
    else     state_q <= state_d;
  end

  assign bus.id_stall   = lu | bus.ex_stall;
  assign bus.ex_valid   = state_q.valid;
  assign bus.ex_a       = ex_a;
  assign bus.ex_b       = ex_b;
  assign bus.ex_imm     = state_q.imm;
  assign bus.ex_dst     = state_q.dst;
  assign bus.ex_ctrl    = state_q.ctrl;
  assign bus.ex_rs      = state_q.rs;
  assign bus.ex_rt      = state_q.rt;
  assign bus.ex_wreg    = state_q.wreg & state_q.valid;
  assign bus.ex_memread = state_q.memread & state_q.valid;
endmodule
